// File: rtl/irq_pkg.sv
// Shared types and sizes for the interrupt request latch and its priority selector.
// No logic; no latency or backpressure of its own.
package irq_pkg;

  localparam int NUM_REQ   = 4;
  localparam int CODE_W    = 2;
  localparam int HOLDOFF_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Highest-set-index selector over the eligible request vector.
// Purely combinational: zero latency, no backpressure.
module irq_prio_sel
  import irq_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_vec,
  output logic [CODE_W-1:0]  o_idx,
  output logic               o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    // Ascending scan so the highest set index is the last one written.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_vec[i]) o_idx = CODE_W'(i);
    end
  end

endmodule

// File: rtl/irq_req_latch.sv
// Latches request rising edges and offers the highest unmasked pending index over valid/ready.
// Edge to code_valid takes 2 cycles; code is held until code_ready, then HOLDOFF idle cycles follow.
module irq_req_latch #(
  parameter int HOLDOFF = 2,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         mask,
  input  logic                       clr_all,
  output logic                       code_valid,
  output logic [irq_pkg::CODE_W-1:0] code,
  input  logic                       code_ready,
  output logic [NUM_REQ-1:0]         pending,
  output logic                       overflow
);
  import irq_pkg::*;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   r_req_q;
  logic [NUM_REQ-1:0]   r_pending;
  logic [NUM_REQ-1:0]   w_rise;
  logic [NUM_REQ-1:0]   w_xfer_clr;
  logic [NUM_REQ-1:0]   w_pend_nxt;
  logic [NUM_REQ-1:0]   w_eligible;
  logic                 r_overflow;
  logic                 w_xfer;
  logic                 w_ovf_hit;
  logic                 w_sel_any;
  logic                 w_load_code;
  logic [CODE_W-1:0]    r_code;
  logic [CODE_W-1:0]    w_sel_idx;
  logic [HOLDOFF_W-1:0] r_hold_cnt;
  logic [HOLDOFF_W-1:0] w_hold_nxt;

  assign w_rise     = req & ~r_req_q;
  assign w_eligible = r_pending & ~mask;
  assign w_xfer     = code_valid & code_ready;

  always_comb begin
    w_xfer_clr = '0;
    if (w_xfer) w_xfer_clr[r_code] = 1'b1;
  end

  // A same-cycle edge re-sets a bit being consumed or cleared, so it is never counted as lost.
  assign w_ovf_hit  = |(w_rise & r_pending & ~w_xfer_clr);
  assign w_pend_nxt = (clr_all ? '0 : (r_pending & ~w_xfer_clr)) | w_rise;

  irq_prio_sel u_prio_sel (
    .i_vec (w_eligible),
    .o_idx (w_sel_idx),
    .o_any (w_sel_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_load_code = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (en && w_sel_any) begin
          w_state_nxt = ST_OFFER;
          w_load_code = 1'b1;
        end
      end
      ST_OFFER: begin
        if (code_ready) begin
          if (HOLDOFF > 0) begin
            w_state_nxt = ST_HOLDOFF;
            w_hold_nxt  = HOLDOFF_W'(HOLDOFF);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        w_hold_nxt = r_hold_cnt - HOLDOFF_W'(1);
        if (r_hold_cnt <= HOLDOFF_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_req_q    <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_code     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_req_q    <= req;
      r_pending  <= w_pend_nxt;
      if (clr_all)        r_overflow <= 1'b0;
      else if (w_ovf_hit) r_overflow <= 1'b1;
      if (w_load_code)    r_code     <= w_sel_idx;
    end
  end

  // Decoded from state so an asynchronous reset withdraws an offer immediately.
  assign code_valid = (r_state == ST_OFFER);
  assign code       = r_code;
  assign pending    = r_pending;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_irq_req_latch.sv
// Scoreboarded bench: a timestamp-based reference model predicts offers, a negedge monitor checks them.
// Directed scenarios for the documented corner cases, then a randomized phase.
module tb_irq_req_latch;

  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] mask;
  logic       clr_all;
  logic       code_valid;
  logic [1:0] code;
  logic       code_ready;
  logic [3:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  irq_req_latch #(.HOLDOFF(H), .NUM_REQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .mask       (mask),
    .clr_all    (clr_all),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (code_ready),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending bits as a set, offers gated by the earliest cycle a new decision may occur.
  int          exp_q[$];
  int          seen_code[$];
  int          seen_cyc[$];
  bit [3:0]    m_pend, m_prev, m_rise, m_cleared;
  bit          m_ovf;
  int          m_offer;
  int unsigned m_cyc, m_ready_at, mon_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_ovf = 1'b0; m_offer = -1;
      m_cyc = 0; m_ready_at = 0;
      exp_q.delete();
    end else begin
      m_rise    = req & ~m_prev;
      m_prev    = req;
      m_cleared = '0;
      if (m_offer >= 0) begin
        if (code_ready) begin
          m_cleared[m_offer] = 1'b1;
          m_ready_at = m_cyc + H + 1;
          m_offer = -1;
        end
      end else if (en && m_cyc >= m_ready_at) begin
        for (int i = 3; i >= 0; i--) begin
          if (m_pend[i] && !mask[i]) begin
            m_offer = i;
            exp_q.push_back(i);
            break;
          end
        end
      end
      if (clr_all) begin
        m_pend = '0;
        m_ovf  = 1'b0;
      end else begin
        if ((m_rise & m_pend & ~m_cleared) != 0) m_ovf = 1'b1;
        m_pend = m_pend & ~m_cleared;
      end
      m_pend = m_pend | m_rise;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      mon_cyc++;
      check("mon_valid", code_valid, (m_offer >= 0) ? 1 : 0);
      check("mon_pending", pending, m_pend);
      check("mon_overflow", overflow, m_ovf);
      if (code_valid === 1'b1 && code_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_xfer", 1, 0);
        end else begin
          check("mon_xfer_code", code, exp_q.pop_front());
        end
        seen_code.push_back(int'(code));
        seen_cyc.push_back(int'(mon_cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req = '0; mask = '0; en = 1'b1; code_ready = 1'b1; clr_all = 1'b1;
    tick(1);
    clr_all = 1'b0;
    tick(8);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0; mask = '0; clr_all = 1'b0; code_ready = 1'b0;
    #1;
    check("rst_valid", code_valid, 0);
    check("rst_code", code, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drain();

    // Single request: two cycles to offer, pending clear after transfer.
    req = 4'b0100;
    tick(1);
    req = '0;
    check("lat_pending_set", pending, 4'b0100);
    check("lat_not_yet_valid", code_valid, 0);
    tick(1);
    check("lat_valid", code_valid, 1);
    check("lat_code", code, 2);
    tick(1);
    check("lat_pending_clr", pending, 0);
    drain();

    // Simultaneous requests drain in priority order with holdoff gaps.
    seen_code.delete(); seen_cyc.delete();
    req = 4'b1011;
    tick(1);
    req = '0;
    tick(16);
    check("prio_count", seen_code.size(), 3);
    if (seen_code.size() == 3) begin
      check("prio_first", seen_code[0], 3);
      check("prio_second", seen_code[1], 1);
      check("prio_third", seen_code[2], 0);
      check("prio_gap1", (seen_cyc[1] - seen_cyc[0]) >= H + 1, 1);
      check("prio_gap2", (seen_cyc[2] - seen_cyc[1]) >= H + 1, 1);
    end
    drain();

    // Lost request sets sticky overflow; clr_all wipes both.
    en = 1'b0;
    req = 4'b0010; tick(1); req = '0; tick(1);
    check("ovf_pend", pending, 4'b0010);
    check("ovf_clear_before", overflow, 0);
    req = 4'b0010; tick(1); req = '0; tick(1);
    check("ovf_set", overflow, 1);
    clr_all = 1'b1; tick(1); clr_all = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("ovf_pend_cleared", pending, 0);
    drain();

    // Masked high bit: low bit offered, and the offer is frozen after unmasking.
    code_ready = 1'b0; mask = 4'b1000; req = 4'b1001;
    tick(1);
    req = '0;
    tick(1);
    check("mask_valid", code_valid, 1);
    check("mask_code", code, 0);
    mask = '0;
    tick(3);
    check("mask_hold_valid", code_valid, 1);
    check("mask_hold_code", code, 0);
    code_ready = 1'b1;
    tick(1);
    drain();

    // Asynchronous reset mid-offer, request held through release.
    code_ready = 1'b0; req = 4'b0010;
    tick(2);
    check("arst_pre_valid", code_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid_drop", code_valid, 0);
    check("arst_pending", pending, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    check("arst_rel1_valid", code_valid, 0);
    check("arst_rel1_pending", pending, 4'b0010);
    tick(1);
    check("arst_rel2_valid", code_valid, 1);
    check("arst_rel2_code", code, 1);
    drain();

    // New edge on the bit being transferred: set wins, no overflow, re-offered after holdoff.
    code_ready = 1'b0; req = 4'b0100;
    tick(1);
    req = '0;
    tick(1);
    check("setwin_offer", code_valid, 1);
    req = 4'b0100; code_ready = 1'b1;
    tick(1);
    req = '0;
    check("setwin_pending", pending, 4'b0100);
    check("setwin_ovf", overflow, 0);
    check("setwin_gap", code_valid, 0);
    tick(H + 1);
    check("setwin_reoffer", code_valid, 1);
    check("setwin_code", code, 2);
    drain();

    // Randomized traffic, checked entirely by the monitor.
    for (int c = 0; c < 800; c++) begin
      req        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      en         = ($urandom_range(0, 9) != 0);
      code_ready = 1'($urandom_range(0, 1));
      clr_all    = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    drain();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
